// File: rtl/flash_dma_mc.sv
// ---------------------------------------------------------------------------
// flash_dma_mc
//
// Multi-channel flash-to-PSRAM DMA engine. NUM_CH independent descriptor
// channels share one transfer engine. Pending channels are served in
// round-robin order. Each channel can run in byte mode or in 16-bit word-pack
// mode. The engine sits between the flash controller (byte stream) and the
// PSRAM wrapper (16-bit write port). It preloads ROM, charset and colour
// images into PSRAM at boot and on demand.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   ch_src_addr         per-channel flash byte source address (24 bits each)
//   ch_dst_addr         per-channel PSRAM byte destination address (22 bits each)
//   ch_length           per-channel byte count (LEN_W bits each)
//   ch_word_mode        per-channel: 1 = pack byte pairs into 16-bit writes
//   ch_start            per-channel 1-cycle request pulse
//   ch_busy             per-channel pending-or-active flag
//   ch_done             per-channel 1-cycle completion pulse
//   flash_addr          flash read start address
//   flash_req_r_addr    pulse: start a read at flash_addr
//   flash_req_r_next    pulse: fetch the next sequential byte
//   flash_d_ready       pulse from flash: flash_d_out valid
//   flash_d_out         flash read data
//   psram_w_strobe      1-cycle PSRAM write pulse
//   psram_addr          PSRAM byte address
//   psram_d_in          PSRAM write data
//   psram_byte_write    1 = single-byte write
//   psram_busy          PSRAM controller busy
//   ch_checksum         per-channel 16-bit byte sum (FLASH_DMA_CHECKSUM_EN only)
//
// Optional feature macro: FLASH_DMA_CHECKSUM_EN
// ---------------------------------------------------------------------------
module flash_dma_mc #(
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*24-1:0]    ch_src_addr,
  input  logic [NUM_CH*22-1:0]    ch_dst_addr,
  input  logic [NUM_CH*LEN_W-1:0] ch_length,
  input  logic [NUM_CH-1:0]       ch_word_mode,
  input  logic [NUM_CH-1:0]       ch_start,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [23:0]             flash_addr,
  output logic                    flash_req_r_addr,
  output logic                    flash_req_r_next,
  input  logic                    flash_d_ready,
  input  logic [7:0]              flash_d_out,
  output logic                    psram_w_strobe,
  output logic [21:0]             psram_addr,
  output logic [15:0]             psram_d_in,
  output logic                    psram_byte_write,
  input  logic                    psram_busy
`ifdef FLASH_DMA_CHECKSUM_EN
  ,
  output logic [NUM_CH*16-1:0]    ch_checksum
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FL_ADDR,
    S_FL_WAIT,
    S_ASSEMBLE,
    S_PS_WRITE,
    S_PS_WAIT,
    S_FL_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [23:0]       src_q, src_d;
  logic [21:0]       dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              word_q, word_d;
  logic              have_lo_q, have_lo_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        data_q, data_d;
  logic              grace_q, grace_d;

  logic [23:0]       flash_addr_q, flash_addr_d;
  logic              flash_req_r_addr_q, flash_req_r_addr_d;
  logic              flash_req_r_next_q, flash_req_r_next_d;
  logic              psram_w_strobe_q, psram_w_strobe_d;
  logic [21:0]       psram_addr_q, psram_addr_d;
  logic [15:0]       psram_d_in_q, psram_d_in_d;
  logic              psram_byte_write_q, psram_byte_write_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;

`ifdef FLASH_DMA_CHECKSUM_EN
  logic [NUM_CH-1:0][15:0] csum_q, csum_d;
`else
  // Checksum disabled: no per-channel sum registers and no adder.
`endif

  // Unpack the flat descriptor buses so the granted channel can be selected
  // with a narrow index.
  logic [23:0]      src_arr [NUM_CH];
  logic [21:0]      dst_arr [NUM_CH];
  logic [LEN_W-1:0] len_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign src_arr[i] = ch_src_addr[i*24 +: 24];
    assign dst_arr[i] = ch_dst_addr[i*22 +: 22];
    assign len_arr[i] = ch_length[i*LEN_W +: LEN_W];
  end

  // Next-state logic: start capture, round-robin arbitration and the
  // transfer sequencer.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    logic            found;
    logic [CH_W-1:0] sel;

    idx                = 0;
    cand               = '0;
    found              = 1'b0;
    sel                = '0;

    state_d            = state_q;
    rr_d               = rr_q;
    grant_d            = grant_q;
    src_d              = src_q;
    dst_d              = dst_q;
    rem_d              = rem_q;
    word_d             = word_q;
    have_lo_d          = have_lo_q;
    lo_d               = lo_q;
    data_d             = data_q;
    grace_d            = grace_q;
    flash_addr_d       = flash_addr_q;
    flash_req_r_addr_d = 1'b0;
    flash_req_r_next_d = 1'b0;
    psram_w_strobe_d   = 1'b0;
    psram_addr_d       = psram_addr_q;
    psram_d_in_d       = psram_d_in_q;
    psram_byte_write_d = psram_byte_write_q;
    ch_done_d          = '0;
`ifdef FLASH_DMA_CHECKSUM_EN
    csum_d             = csum_q;
`endif

    // A start on an already pending channel changes nothing, so OR-ing is
    // enough to ignore it.
    pending_d = pending_q | ch_start;

    // Lowest-index pending channel at or after the round-robin pointer.
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d   = sel;
          src_d     = src_arr[sel];
          dst_d     = dst_arr[sel];
          rem_d     = len_arr[sel];
          // An odd destination cannot take aligned word writes, so the whole
          // channel runs in byte mode.
          word_d    = ch_word_mode[sel] & ~dst_arr[sel][0];
          have_lo_d = 1'b0;
`ifdef FLASH_DMA_CHECKSUM_EN
          csum_d[sel] = 16'h0000;
`endif
          state_d   = (len_arr[sel] == '0) ? S_DONE : S_FL_ADDR;
        end
      end

      S_FL_ADDR: begin
        flash_addr_d       = src_q;
        flash_req_r_addr_d = 1'b1;
        state_d            = S_FL_WAIT;
      end

      S_FL_WAIT: begin
        if (flash_d_ready) begin
          data_d  = flash_d_out;
          rem_d   = rem_q - LEN_W'(1);
`ifdef FLASH_DMA_CHECKSUM_EN
          csum_d[grant_q] = csum_q[grant_q] + {8'h00, flash_d_out};
`endif
          state_d = S_ASSEMBLE;
        end
      end

      S_ASSEMBLE: begin
        // rem_q already counts the byte just captured, so rem_q==0 with no
        // low byte held means this is an odd tail byte.
        if (!word_q || (!have_lo_q && rem_q == '0)) begin
          psram_addr_d       = dst_q;
          psram_d_in_d       = {data_q, data_q};
          psram_byte_write_d = 1'b1;
          dst_d              = dst_q + 22'd1;
          state_d            = S_PS_WRITE;
        end else if (!have_lo_q) begin
          lo_d      = data_q;
          have_lo_d = 1'b1;
          state_d   = S_FL_NEXT;
        end else begin
          psram_addr_d       = dst_q;
          psram_d_in_d       = {data_q, lo_q};
          psram_byte_write_d = 1'b0;
          dst_d              = dst_q + 22'd2;
          have_lo_d          = 1'b0;
          state_d            = S_PS_WRITE;
        end
      end

      S_PS_WRITE: begin
        if (!psram_busy) begin
          psram_w_strobe_d = 1'b1;
          grace_d          = 1'b1;
          state_d          = S_PS_WAIT;
        end
      end

      S_PS_WAIT: begin
        // The PSRAM wrapper raises busy one cycle after the strobe, so the
        // first cycle here is skipped before trusting psram_busy.
        if (grace_q) begin
          grace_d = 1'b0;
        end else if (!psram_busy) begin
          state_d = (rem_q == '0) ? S_DONE : S_FL_NEXT;
        end
      end

      S_FL_NEXT: begin
        flash_req_r_next_d = 1'b1;
        state_d            = S_FL_WAIT;
      end

      S_DONE: begin
        ch_done_d[grant_q] = 1'b1;
        pending_d[grant_q] = 1'b0;
        if (grant_q == CH_W'(NUM_CH - 1)) rr_d = '0;
        else                              rr_d = grant_q + 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      pending_q          <= '0;
      rr_q               <= '0;
      grant_q            <= '0;
      src_q              <= '0;
      dst_q              <= '0;
      rem_q              <= '0;
      word_q             <= 1'b0;
      have_lo_q          <= 1'b0;
      lo_q               <= '0;
      data_q             <= '0;
      grace_q            <= 1'b0;
      flash_addr_q       <= '0;
      flash_req_r_addr_q <= 1'b0;
      flash_req_r_next_q <= 1'b0;
      psram_w_strobe_q   <= 1'b0;
      psram_addr_q       <= '0;
      psram_d_in_q       <= '0;
      psram_byte_write_q <= 1'b0;
      ch_done_q          <= '0;
`ifdef FLASH_DMA_CHECKSUM_EN
      csum_q             <= '0;
`endif
    end else begin
      state_q            <= state_d;
      pending_q          <= pending_d;
      rr_q               <= rr_d;
      grant_q            <= grant_d;
      src_q              <= src_d;
      dst_q              <= dst_d;
      rem_q              <= rem_d;
      word_q             <= word_d;
      have_lo_q          <= have_lo_d;
      lo_q               <= lo_d;
      data_q             <= data_d;
      grace_q            <= grace_d;
      flash_addr_q       <= flash_addr_d;
      flash_req_r_addr_q <= flash_req_r_addr_d;
      flash_req_r_next_q <= flash_req_r_next_d;
      psram_w_strobe_q   <= psram_w_strobe_d;
      psram_addr_q       <= psram_addr_d;
      psram_d_in_q       <= psram_d_in_d;
      psram_byte_write_q <= psram_byte_write_d;
      ch_done_q          <= ch_done_d;
`ifdef FLASH_DMA_CHECKSUM_EN
      csum_q             <= csum_d;
`endif
    end
  end

  assign ch_busy          = pending_q;
  assign ch_done          = ch_done_q;
  assign flash_addr       = flash_addr_q;
  assign flash_req_r_addr = flash_req_r_addr_q;
  assign flash_req_r_next = flash_req_r_next_q;
  assign psram_w_strobe   = psram_w_strobe_q;
  assign psram_addr       = psram_addr_q;
  assign psram_d_in       = psram_d_in_q;
  assign psram_byte_write = psram_byte_write_q;
`ifdef FLASH_DMA_CHECKSUM_EN
  assign ch_checksum      = csum_q;
`endif

endmodule

// File: tb/tb_flash_dma_mc.sv
// ---------------------------------------------------------------------------
// tb_flash_dma_mc
//
// Directed testbench for flash_dma_mc (NUM_CH=2). It contains a flash model
// whose byte at address a is (a[7:0] + 1), returned three cycles after each
// request. It also contains a PSRAM model that logs every write and holds
// busy for two cycles after each strobe. Each test task drives its own
// scenario and checks the results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_flash_dma_mc;

  localparam int NUM_CH = 2;
  localparam int LEN_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NUM_CH*24-1:0]    ch_src_addr = '0;
  logic [NUM_CH*22-1:0]    ch_dst_addr = '0;
  logic [NUM_CH*LEN_W-1:0] ch_length = '0;
  logic [NUM_CH-1:0]       ch_word_mode = '0;
  logic [NUM_CH-1:0]       ch_start = '0;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_done;
  logic [23:0]             flash_addr;
  logic                    flash_req_r_addr;
  logic                    flash_req_r_next;
  logic                    flash_d_ready = 1'b0;
  logic [7:0]              flash_d_out = '0;
  logic                    psram_w_strobe;
  logic [21:0]             psram_addr;
  logic [15:0]             psram_d_in;
  logic                    psram_byte_write;
  logic                    psram_busy = 1'b0;
`ifdef FLASH_DMA_CHECKSUM_EN
  logic [NUM_CH*16-1:0]    ch_checksum;
`endif

  flash_dma_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ch_src_addr      (ch_src_addr),
    .ch_dst_addr      (ch_dst_addr),
    .ch_length        (ch_length),
    .ch_word_mode     (ch_word_mode),
    .ch_start         (ch_start),
    .ch_busy          (ch_busy),
    .ch_done          (ch_done),
    .flash_addr       (flash_addr),
    .flash_req_r_addr (flash_req_r_addr),
    .flash_req_r_next (flash_req_r_next),
    .flash_d_ready    (flash_d_ready),
    .flash_d_out      (flash_d_out),
    .psram_w_strobe   (psram_w_strobe),
    .psram_addr       (psram_addr),
    .psram_d_in       (psram_d_in),
    .psram_byte_write (psram_byte_write),
    .psram_busy       (psram_busy)
`ifdef FLASH_DMA_CHECKSUM_EN
    ,
    .ch_checksum      (ch_checksum)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] wr_addr [$];
  logic [15:0] wr_data [$];
  logic        wr_bw   [$];
  int          done_ch [$];
  int          rd_addr_cnt, rd_next_cnt, ready_cnt, strobe_cnt, viol;
  bit          ps_stall = 1'b0;

  // Flash and PSRAM models plus the done monitor. One process handles all of
  // them, so their ordering within a cycle is fixed.
  initial begin
    int          fl_delay;
    int          ps_cnt;
    logic [23:0] fl_ptr;
    fl_delay = -1;
    ps_cnt   = 0;
    fl_ptr   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        flash_d_ready = 1'b0;
        psram_busy    = 1'b0;
        fl_delay      = -1;
        ps_cnt        = 0;
        continue;
      end
      if (psram_w_strobe) begin
        if (psram_busy) viol++;
        wr_addr.push_back(psram_addr);
        wr_data.push_back(psram_d_in);
        wr_bw.push_back(psram_byte_write);
        strobe_cnt++;
        ps_cnt = 2;
      end else if (ps_cnt > 0) begin
        ps_cnt--;
      end
      for (int c = 0; c < NUM_CH; c++) if (ch_done[c]) done_ch.push_back(c);
      flash_d_ready = 1'b0;
      if (flash_req_r_addr) begin
        fl_ptr = flash_addr;
        fl_delay = 2;
        rd_addr_cnt++;
      end else if (flash_req_r_next) begin
        fl_ptr = fl_ptr + 24'd1;
        fl_delay = 2;
        rd_next_cnt++;
      end else if (fl_delay > 0) begin
        fl_delay--;
        if (fl_delay == 0) begin
          flash_d_ready = 1'b1;
          flash_d_out   = fl_ptr[7:0] + 8'h01;
          fl_delay      = -1;
          ready_cnt++;
          if (ps_stall) ps_cnt = 3;
        end
      end
      psram_busy = (ps_cnt > 0);
    end
  end

  task automatic set_desc(input int ch, input logic [23:0] src, input logic [21:0] dst,
                          input logic [15:0] len, input logic wm);
    ch_src_addr[ch*24 +: 24]       = src;
    ch_dst_addr[ch*22 +: 22]       = dst;
    ch_length[ch*LEN_W +: LEN_W]   = len;
    ch_word_mode[ch]               = wm;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_bw.delete(); done_ch.delete();
    rd_addr_cnt = 0; rd_next_cnt = 0; ready_cnt = 0; strobe_cnt = 0; viol = 0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    @(negedge clk); ch_start = m;
    @(negedge clk); ch_start = '0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_ch.size() >= n) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ch_busy, ch_done, flash_req_r_addr, flash_req_r_next, psram_w_strobe, psram_byte_write} !== '0) begin
      n_err++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {ch_busy, ch_done, flash_req_r_addr, flash_req_r_next, psram_w_strobe, psram_byte_write}); end
    n_cmp++; if ({flash_addr, psram_addr, psram_d_in} !== '0) begin
      n_err++; $display("[TB] FAIL reset_data: got %h expected 0", {flash_addr, psram_addr, psram_d_in}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ch_busy, ch_done} !== '0) begin
      n_err++; $display("[TB] FAIL after_reset_idle: got %b expected 0", {ch_busy, ch_done}); end
  endtask

  task automatic test_byte_mode();
    bit ok;
    $display("[TB] test_byte_mode");
    clear_log();
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd8, 1'b0);
    pulse_start(2'b01);
    n_cmp++; if (ch_busy !== 2'b01) begin n_err++; $display("[TB] FAIL byte_busy: got %b expected 01", ch_busy); end
    repeat (5) @(negedge clk);
    pulse_start(2'b01);
    wait_done(1, ok);
    repeat (40) @(negedge clk);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL byte_timeout: got no done expected done"); end
    n_cmp++; if (wr_addr.size() !== 8) begin n_err++; $display("[TB] FAIL byte_count: got %0d expected 8", wr_addr.size()); end
    for (int n = 0; n < 8 && n < wr_addr.size(); n++) begin
      logic [7:0] b;
      b = 8'(n + 1);
      n_cmp++; if ({wr_addr[n], wr_data[n], wr_bw[n]} !== {22'h03D400 + 22'(n), b, b, 1'b1}) begin
        n_err++; $display("[TB] FAIL byte_write[%0d]: got %h/%h/%b expected %h/%h/1", n, wr_addr[n], wr_data[n], wr_bw[n], 22'h03D400 + 22'(n), {b, b}); end
    end
    n_cmp++; if (done_ch.size() !== 1) begin n_err++; $display("[TB] FAIL byte_done_cnt: got %0d expected 1", done_ch.size()); end
    n_cmp++; if ({rd_addr_cnt, rd_next_cnt, viol} !== {32'd1, 32'd7, 32'd0}) begin
      n_err++; $display("[TB] FAIL byte_flash_traffic: got %0d/%0d/%0d expected 1/7/0", rd_addr_cnt, rd_next_cnt, viol); end
  endtask

  task automatic test_word_mode();
    bit ok;
    $display("[TB] test_word_mode");
    clear_log();
    ps_stall = 1'b1;
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd8, 1'b1);
    pulse_start(2'b01);
    wait_done(1, ok);
    ps_stall = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL word_timeout: got no done expected done"); end
    n_cmp++; if (wr_addr.size() !== 4) begin n_err++; $display("[TB] FAIL word_count: got %0d expected 4", wr_addr.size()); end
    for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
      logic [15:0] d;
      d = {8'(2*k + 2), 8'(2*k + 1)};
      n_cmp++; if ({wr_addr[k], wr_data[k], wr_bw[k]} !== {22'h03D400 + 22'(2*k), d, 1'b0}) begin
        n_err++; $display("[TB] FAIL word_write[%0d]: got %h/%h/%b expected %h/%h/0", k, wr_addr[k], wr_data[k], wr_bw[k], 22'h03D400 + 22'(2*k), d); end
    end
    n_cmp++; if ({ready_cnt, viol} !== {32'd8, 32'd0}) begin
      n_err++; $display("[TB] FAIL word_ready_viol: got %0d/%0d expected 8/0", ready_cnt, viol); end
  endtask

  task automatic test_odd_word();
    bit ok;
    logic [21:0] ea [3];
    logic [15:0] ed [3];
    logic        eb [3];
    $display("[TB] test_odd_word");
    ea = '{22'h03D400, 22'h03D402, 22'h03D404};
    ed = '{16'h0201, 16'h0403, 16'h0505};
    eb = '{1'b0, 1'b0, 1'b1};
    clear_log();
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd5, 1'b1);
    pulse_start(2'b01);
    wait_done(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL odd_timeout: got no done expected done"); end
    n_cmp++; if ({wr_addr.size(), ready_cnt} !== {32'd3, 32'd5}) begin
      n_err++; $display("[TB] FAIL odd_counts: got %0d/%0d expected 3/5", wr_addr.size(), ready_cnt); end
    for (int k = 0; k < 3 && k < wr_addr.size(); k++) begin
      n_cmp++; if ({wr_addr[k], wr_data[k], wr_bw[k]} !== {ea[k], ed[k], eb[k]}) begin
        n_err++; $display("[TB] FAIL odd_write[%0d]: got %h/%h/%b expected %h/%h/%b", k, wr_addr[k], wr_data[k], wr_bw[k], ea[k], ed[k], eb[k]); end
    end
  endtask

  task automatic test_odd_dst();
    bit ok;
    $display("[TB] test_odd_dst");
    clear_log();
    set_desc(0, 24'hA1B200, 22'h03D401, 16'd3, 1'b1);
    pulse_start(2'b01);
    wait_done(1, ok);
    n_cmp++; if (wr_addr.size() !== 3 || !ok) begin
      n_err++; $display("[TB] FAIL odd_dst_count: got %0d expected 3", wr_addr.size()); end
    for (int n = 0; n < 3 && n < wr_addr.size(); n++) begin
      logic [7:0] b;
      b = 8'(n + 1);
      n_cmp++; if ({wr_addr[n], wr_data[n], wr_bw[n]} !== {22'h03D401 + 22'(n), b, b, 1'b1}) begin
        n_err++; $display("[TB] FAIL odd_dst_write[%0d]: got %h/%h/%b expected %h/%h/1", n, wr_addr[n], wr_data[n], wr_bw[n], 22'h03D401 + 22'(n), {b, b}); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    $display("[TB] test_wrap");
    clear_log();
    set_desc(0, 24'hFFFFFF, 22'h3FFFFF, 16'd2, 1'b0);
    pulse_start(2'b01);
    wait_done(1, ok);
    n_cmp++; if (flash_addr !== 24'hFFFFFF || !ok) begin
      n_err++; $display("[TB] FAIL wrap_flash_addr: got %h expected ffffff", flash_addr); end
    n_cmp++; if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {22'h3FFFFF, 16'h0000, 22'h000000, 16'h0101}) begin
      n_err++; $display("[TB] FAIL wrap_writes: got %h/%h %h/%h expected 3fffff/0000 000000/0101", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
  endtask

  task automatic test_len_zero();
    bit ok;
    $display("[TB] test_len_zero");
    clear_log();
    set_desc(1, 24'h000100, 22'h001000, 16'd0, 1'b0);
    @(negedge clk); ch_start = 2'b10;
    @(negedge clk); ch_start = 2'b00;
    n_cmp++; if ({ch_busy[1], ch_done} !== 3'b100) begin
      n_err++; $display("[TB] FAIL len0_cycle1: got busy %b done %b expected 1 00", ch_busy[1], ch_done); end
    @(negedge clk);
    n_cmp++; if (ch_done !== 2'b00) begin n_err++; $display("[TB] FAIL len0_cycle2: got %b expected 00", ch_done); end
    @(negedge clk);
    n_cmp++; if ({ch_busy[1], ch_done} !== 3'b010) begin
      n_err++; $display("[TB] FAIL len0_done: got busy %b done %b expected 0 10", ch_busy[1], ch_done); end
    ch_start = 2'b10;
    @(negedge clk); ch_start = 2'b00;
    n_cmp++; if ({ch_busy[1], ch_done} !== 3'b100) begin
      n_err++; $display("[TB] FAIL len0_restart: got busy %b done %b expected 1 00", ch_busy[1], ch_done); end
    wait_done(2, ok);
    n_cmp++; if ({ok, 32'(done_ch.size()), strobe_cnt, rd_addr_cnt} !== {1'b1, 32'd2, 32'd0, 32'd0}) begin
      n_err++; $display("[TB] FAIL len0_traffic: got ok %b done %0d strobes %0d reads %0d expected 1 2 0 0", ok, done_ch.size(), strobe_cnt, rd_addr_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    $display("[TB] test_back_to_back");
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd2, 1'b0);
    set_desc(1, 24'h000010, 22'h001000, 16'd2, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      pulse_start(2'b11);
      n_cmp++; if (ch_busy !== 2'b11) begin n_err++; $display("[TB] FAIL rr_busy[%0d]: got %b expected 11", pass, ch_busy); end
      wait_done(2, ok);
      n_cmp++; if ({ok, done_ch[0], done_ch[1]} !== {1'b1, 32'd0, 32'd1}) begin
        n_err++; $display("[TB] FAIL rr_order[%0d]: got %0d,%0d expected 0,1", pass, done_ch[0], done_ch[1]); end
      n_cmp++; if ({wr_addr[0], wr_addr[2], wr_data[2]} !== {22'h03D400, 22'h001000, 16'h1111}) begin
        n_err++; $display("[TB] FAIL rr_writes[%0d]: got %h %h/%h expected 03d400 001000/1111", pass, wr_addr[0], wr_addr[2], wr_data[2]); end
    end
    clear_log();
    pulse_start(2'b01);
    wait_done(1, ok);
    clear_log();
    pulse_start(2'b11);
    wait_done(2, ok);
    n_cmp++; if ({ok, done_ch[0], done_ch[1], wr_addr[0]} !== {1'b1, 32'd1, 32'd0, 22'h001000}) begin
      n_err++; $display("[TB] FAIL rr_rotate: got %0d,%0d first %h expected 1,0 first 001000", done_ch[0], done_ch[1], wr_addr[0]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    $display("[TB] test_reset_mid");
    clear_log();
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd8, 1'b1);
    pulse_start(2'b01);
    for (int i = 0; i < 1000 && strobe_cnt < 2; i++) @(negedge clk);
    n_cmp++; if (strobe_cnt < 2) begin n_err++; $display("[TB] FAIL mid_progress: got %0d strobes expected 2", strobe_cnt); end
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({ch_busy, ch_done, flash_req_r_addr, flash_req_r_next, psram_w_strobe, psram_byte_write} !== '0) begin
      n_err++; $display("[TB] FAIL mid_reset_ctrl: got %b expected 0", {ch_busy, ch_done, flash_req_r_addr, flash_req_r_next, psram_w_strobe, psram_byte_write}); end
    n_cmp++; if ({flash_addr, psram_addr, psram_d_in} !== '0) begin
      n_err++; $display("[TB] FAIL mid_reset_data: got %h expected 0", {flash_addr, psram_addr, psram_d_in}); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (done_ch.size() !== 0) begin n_err++; $display("[TB] FAIL mid_no_done: got %0d expected 0", done_ch.size()); end
    clear_log();
    set_desc(0, 24'hA1B200, 22'h03D400, 16'd8, 1'b0);
    pulse_start(2'b01);
    wait_done(1, ok);
    n_cmp++; if ({ok, 32'(wr_addr.size()), 32'(done_ch.size())} !== {1'b1, 32'd8, 32'd1}) begin
      n_err++; $display("[TB] FAIL post_reset_run: got ok %b writes %0d done %0d expected 1 8 1", ok, wr_addr.size(), done_ch.size()); end
    for (int n = 0; n < 8 && n < wr_addr.size(); n++) begin
      n_cmp++; if ({wr_addr[n], wr_data[n]} !== {22'h03D400 + 22'(n), 8'(n + 1), 8'(n + 1)}) begin
        n_err++; $display("[TB] FAIL post_reset_write[%0d]: got %h/%h expected %h/%h", n, wr_addr[n], wr_data[n], 22'h03D400 + 22'(n), {8'(n + 1), 8'(n + 1)}); end
    end
`ifdef FLASH_DMA_CHECKSUM_EN
    n_cmp++; if (ch_checksum[15:0] !== 16'h0024) begin
      n_err++; $display("[TB] FAIL checksum_ch0: got %h expected 0024", ch_checksum[15:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_mode();
    test_word_mode();
    test_odd_word();
    test_odd_dst();
    test_wrap();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
